// File: rtl/i2s_pkg.sv
// Shared widths, channel constants and state encoding for the I2S slave receiver.
package i2s_pkg;

   localparam int unsigned I2S_DATA_W = 16;
   localparam int unsigned I2S_CNT_W  = 6;

   localparam logic CH_LEFT  = 1'b0;
   localparam logic CH_RIGHT = 1'b1;

   typedef enum logic {
      ST_SYNC = 1'b0,
      ST_RUN  = 1'b1
   } i2s_state_t;

endpackage

// File: rtl/i2s_sync_edge.sv
// W-bit two-flop synchroniser into the clk domain.
// When EDGE_EN is set, a third flop on bit 0 yields a one-clk rising-edge strobe.
module i2s_sync_edge #(
   parameter int unsigned W       = 1,
   parameter bit          EDGE_EN = 1'b0
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] i_d,
   output logic [W-1:0] o_q,
   output logic         o_rise
);

   logic [W-1:0] r_meta;
   logic [W-1:0] r_sync;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_meta <= '0;
         r_sync <= '0;
      end else begin
         r_meta <= i_d;
         r_sync <= r_meta;
      end
   end

   assign o_q = r_sync;

   generate
      if (EDGE_EN) begin : g_edge
         logic r_last;
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) r_last <= 1'b0;
            else        r_last <= r_sync[0];
         end
         assign o_rise = r_sync[0] & ~r_last;
      end else begin : g_no_edge
         assign o_rise = 1'b0;
      end
   endgenerate

endmodule

// File: rtl/i2s_rx.sv
// I2S (Philips) slave receiver: deserialises left/right words and emits a stereo frame plus mono mix.
// Define I2S_RX_ERR_CNT_EN to build the saturating short-slot counter behind err_count.
module i2s_rx
   import i2s_pkg::*;
#(
   parameter int unsigned DATA_W = I2S_DATA_W,
   parameter int unsigned CNT_W  = I2S_CNT_W,
   parameter int unsigned ERR_W  = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   input  logic              i2s_bck,
   input  logic              i2s_ws,
   input  logic              i2s_data,
   output logic [DATA_W-1:0] left_sample,
   output logic [DATA_W-1:0] right_sample,
   output logic [DATA_W-1:0] mono_sample,
   output logic              sample_valid,
   output logic              frame_err,
   output logic [ERR_W-1:0]  err_count
);

   localparam logic [CNT_W-1:0] LP_LAST_BIT = CNT_W'(DATA_W - 1);

   logic w_bck_rise, w_bck_lvl_unused, w_wsd_rise_unused;
   logic w_ws_s, w_data_s, w_ws_edge;

   i2s_sync_edge #(.W(1), .EDGE_EN(1'b1)) u_sync_bck (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_d    (i2s_bck),
      .o_q    (w_bck_lvl_unused),
      .o_rise (w_bck_rise)
   );

   i2s_sync_edge #(.W(2), .EDGE_EN(1'b0)) u_sync_wsd (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_d    ({i2s_ws, i2s_data}),
      .o_q    ({w_ws_s, w_data_s}),
      .o_rise (w_wsd_rise_unused)
   );

   i2s_state_t        r_state, w_state_nxt;
   logic              r_ws_prev;
   logic              r_chan, w_chan_nxt;
   logic [CNT_W-1:0]  r_bit_cnt, w_cnt_nxt;
   logic [DATA_W-1:0] r_shreg, w_shreg_nxt;
   logic [DATA_W-1:0] r_left_hold, w_hold_nxt;
   logic              r_left_ok, w_ok_nxt;
   logic [DATA_W-1:0] r_left, w_left_nxt;
   logic [DATA_W-1:0] r_right, w_right_nxt;
   logic [DATA_W-1:0] r_mono, w_mono_nxt;
   logic              r_valid, w_valid_nxt;
   logic              r_ferr, w_ferr_nxt;

   logic [DATA_W-1:0] w_shifted, w_word;
   logic [DATA_W:0]   w_sum;

   assign w_ws_edge = w_bck_rise & (w_ws_s != r_ws_prev);
   assign w_shifted = {r_shreg[DATA_W-2:0], w_data_s};
   // Bits past DATA_W were never shifted, so the boundary bit only joins a word still filling.
   assign w_word    = (r_bit_cnt <= LP_LAST_BIT) ? w_shifted : r_shreg;
   assign w_sum     = {r_left_hold[DATA_W-1], r_left_hold} + {w_word[DATA_W-1], w_word};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_SYNC;
         r_ws_prev   <= 1'b0;
         r_chan      <= CH_LEFT;
         r_bit_cnt   <= '0;
         r_shreg     <= '0;
         r_left_hold <= '0;
         r_left_ok   <= 1'b0;
         r_left      <= '0;
         r_right     <= '0;
         r_mono      <= '0;
         r_valid     <= 1'b0;
         r_ferr      <= 1'b0;
      end else begin
         if (w_bck_rise) r_ws_prev <= w_ws_s;
         r_state     <= w_state_nxt;
         r_chan      <= w_chan_nxt;
         r_bit_cnt   <= w_cnt_nxt;
         r_shreg     <= w_shreg_nxt;
         r_left_hold <= w_hold_nxt;
         r_left_ok   <= w_ok_nxt;
         r_left      <= w_left_nxt;
         r_right     <= w_right_nxt;
         r_mono      <= w_mono_nxt;
         r_valid     <= w_valid_nxt;
         r_ferr      <= w_ferr_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_chan_nxt  = r_chan;
      w_cnt_nxt   = r_bit_cnt;
      w_shreg_nxt = r_shreg;
      w_hold_nxt  = r_left_hold;
      w_ok_nxt    = r_left_ok;
      w_left_nxt  = r_left;
      w_right_nxt = r_right;
      w_mono_nxt  = r_mono;
      w_valid_nxt = 1'b0;
      w_ferr_nxt  = 1'b0;
      if (!en) begin
         w_state_nxt = ST_SYNC;
      end else begin
         case (r_state)
            ST_SYNC: begin
               if (w_ws_edge) begin
                  w_chan_nxt  = w_ws_s;
                  w_cnt_nxt   = '0;
                  w_shreg_nxt = '0;
                  w_ok_nxt    = 1'b0;
                  w_state_nxt = ST_RUN;
               end
            end
            ST_RUN: begin
               if (w_bck_rise && !w_ws_edge) begin
                  if (r_bit_cnt <= LP_LAST_BIT) w_shreg_nxt = w_shifted;
                  if (r_bit_cnt != '1)          w_cnt_nxt   = r_bit_cnt + 1'b1;
               end else if (w_ws_edge) begin
                  if (r_bit_cnt >= LP_LAST_BIT) begin
                     if (r_chan == CH_LEFT) begin
                        w_hold_nxt = w_word;
                        w_ok_nxt   = 1'b1;
                     end else if (r_chan == CH_RIGHT && r_left_ok) begin
                        w_left_nxt  = r_left_hold;
                        w_right_nxt = w_word;
                        w_mono_nxt  = w_sum[DATA_W:1];
                        w_valid_nxt = 1'b1;
                        w_ok_nxt    = 1'b0;
                     end
                  end else begin
                     w_ferr_nxt = 1'b1;
                     w_ok_nxt   = 1'b0;
                  end
                  w_chan_nxt  = w_ws_s;
                  w_cnt_nxt   = '0;
                  w_shreg_nxt = '0;
               end
            end
            default: w_state_nxt = ST_SYNC;
         endcase
      end
   end

   assign left_sample  = r_left;
   assign right_sample = r_right;
   assign mono_sample  = r_mono;
   assign sample_valid = r_valid;
   assign frame_err    = r_ferr;

`ifdef I2S_RX_ERR_CNT_EN
   logic [ERR_W-1:0] r_err_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                            r_err_cnt <= '0;
      else if (w_ferr_nxt && r_err_cnt != '1) r_err_cnt <= r_err_cnt + 1'b1;
   end

   assign err_count = r_err_cnt;
`else
   assign err_count = '0;
`endif

endmodule
